plc_input_filter: RTL and testbench
===================================

// Module: plc_input_filter
// PURPOSE
//   Input-conditioning stage directly upstream of the PLC I/O port block.
//   Synchronises raw digital input pins, debounces each channel, and raises sticky rise/fall event flags.
//   The I/O port block reads the filtered levels and flags, and clears the flags (write-1-to-clear).
//   The core therefore never sees metastable or chattering inputs.
// PARAMETERS
//   CHANNELS         4   number of independent input channels (1..16)
//   SYNC_STAGES      2   synchroniser flop depth per channel (>=2)
//   DEBOUNCE_CYCLES  16  consecutive stable cycles required before the filtered level changes (>=1)
// PORTS
//   clk_in     in   1         system clock
//   rst_in     in   1         asynchronous, active-low reset
//   raw_in     in   CHANNELS  asynchronous raw input pins
//   filt_out   out  CHANNELS  debounced level per channel
//   rise_flag  out  CHANNELS  sticky: filtered 0->1 seen
//   fall_flag  out  CHANNELS  sticky: filtered 1->0 seen
//   flag_clr   in   CHANNELS  1-cycle pulse; clears that channel's rise and fall flags
//   irq        out  1         OR of all rise_flag|fall_flag bits
// BEHAVIOUR
//   - Reset (rst_in=0, async): all sync flops, counters, filt_out, rise_flag and fall_flag go to 0; irq goes to 0.
//     Reset mid-count discards the count. After release, the filter restarts from level 0.
//   - Sync: raw_in passes through a SYNC_STAGES flop chain. sync_q is the last stage.
//   - Per-channel counter, width CNT_W = clog2(DEBOUNCE_CYCLES+1):
//       sync_q == filt_out              -> cnt <= 0
//       sync_q != filt_out, cnt < D-1   -> cnt <= cnt+1
//       sync_q != filt_out, cnt == D-1  -> filt_out <= sync_q, cnt <= 0
//     D = DEBOUNCE_CYCLES. Any single-cycle return to the old level restarts the count (no saturation, no wrap).
//   - Latency: a raw change held stable is visible on filt_out SYNC_STAGES + D rising edges after the first edge that samples it.
//     Pulses shorter than D cycles after synchronisation never reach filt_out.
//   - Event flags (only when PLC_IN_EDGE_EN is defined):
//       filt_out 0->1 sets rise_flag in the same edge filt_out updates.
//       filt_out 1->0 sets fall_flag in the same edge filt_out updates.
//       flag_clr[i]=1 clears both flags of channel i on the next edge.
//       A set and a clear in the same cycle: set wins, and the flag stays 1.
//       Flags never clear on their own.
//   - irq is a combinational OR of the registered flags, so it is glitch-free.
//   - Channels are fully independent. Simultaneous events on several channels are all captured.
// CONFIGURATION
//   PLC_IN_EDGE_EN defined:
//     rise_flag, fall_flag and irq are implemented as above. flag_clr is honoured.
//   PLC_IN_EDGE_EN undefined:
//     No flag logic is built. rise_flag, fall_flag and irq are tied to 0. flag_clr is ignored.
//     filt_out behaviour is unchanged.
// STRUCTURE
//   - Shared package plc_pkg holds:
//       PLC_IN_CHANNELS default
//       clog2-based function for CNT_W
//       localparam for the flag-clear encoding used by io_ports
//   - Sub-module plc_debounce_ch: one channel (synchroniser, counter, level register, edge flags).
//     The top instantiates CHANNELS copies in a generate loop and ORs the flags into irq.
// TESTING  (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. Hold rst_in=0 with raw_in=4'hF.
//      -> filt_out=0, rise_flag=0, fall_flag=0, irq=0.
//      Release reset with raw_in=4'hF -> filt_out=4'hF after exactly 6 edges, and rise_flag=4'hF.
//   2. raw_in[0] 0->1, held.
//      -> filt_out[0]=1 on the 6th edge; rise_flag[0]=1 on the same edge; irq=1.
//      Then flag_clr=4'h1 -> rise_flag[0]=0 and irq=0 on the next edge.
//   3. raw_in[1] high for 3 cycles, then low.
//      -> filt_out[1] stays 0; no flags set.
//      Same test with a 4-cycle pulse -> filt_out[1] pulses high for 4 cycles; rise_flag[1]=1 and fall_flag[1]=1.
//   4. Drive flag_clr[2]=1 in the same cycle that filt_out[2] rises.
//      -> rise_flag[2]=1 afterwards (set wins).
//   5. raw_in[3] toggles every 2 cycles for 20 cycles, then stays high.
//      -> a single filt_out[3] 0->1 transition, 6 edges after the last toggle; exactly one rise event.
//   6. Assert rst_in=0 while a channel count is at 2.
//      -> all outputs go to 0 immediately (async). After release, the count restarts from 0.
//   7. Build without PLC_IN_EDGE_EN and repeat test 2.
//      -> filt_out timing is identical; rise_flag, fall_flag and irq stay 0.

Source files
------------

// File: rtl/plc_pkg.sv
// Shared definitions for the PLC input-conditioning blocks.
// Holds the default channel count, the counter-width helper and the
// flag-clear encoding that the I/O port block drives onto flag_clr.
package plc_pkg;

    // Default number of filtered input channels.
    localparam int PLC_IN_CHANNELS = 4;

    // Level on a flag_clr bit that requests a clear of that channel's flags.
    localparam logic PLC_FLAG_CLR_ACTIVE = 1'b1;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int plc_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/plc_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, filtered level
// register and (when PLC_IN_EDGE_EN is defined) sticky rise/fall flags.
// Without PLC_IN_EDGE_EN the flag outputs are tied low and flag_clr is ignored.
module plc_debounce_ch
    import plc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    input  logic flag_clr,
    output logic filt_out,
    output logic rise_flag,
    output logic fall_flag
);

    localparam int CNT_W = plc_clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_q;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   filt_reg;
    logic                   filt_next;

    // Synchroniser: raw pin shifts in at bit 0, the oldest stage is used.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

    // Debounce: count consecutive cycles that disagree with the filtered
    // level; any agreeing cycle restarts the count from zero.
    always_comb begin
        cnt_next  = '0;
        filt_next = filt_reg;
        if (sync_q != filt_reg) begin
            if (cnt_reg == CNT_LAST) begin
                filt_next = sync_q;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Counter and filtered level registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            filt_reg <= filt_next;
        end
    end

    assign filt_out = filt_reg;

`ifdef PLC_IN_EDGE_EN
    logic rise_reg;
    logic fall_reg;
    logic rise_set;
    logic fall_set;
    logic clr_req;

    assign rise_set = filt_next & ~filt_reg;
    assign fall_set = ~filt_next & filt_reg;
    assign clr_req  = (flag_clr == PLC_FLAG_CLR_ACTIVE);

    // Sticky event flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            if (rise_set) begin
                rise_reg <= 1'b1;
            end else if (clr_req) begin
                rise_reg <= 1'b0;
            end
            if (fall_set) begin
                fall_reg <= 1'b1;
            end else if (clr_req) begin
                fall_reg <= 1'b0;
            end
        end
    end

    assign rise_flag = rise_reg;
    assign fall_flag = fall_reg;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign rise_flag       = 1'b0;
    assign fall_flag       = 1'b0;
`endif

endmodule

// File: rtl/plc_input_filter.sv
// PLC input-conditioning stage: CHANNELS independent debounced inputs with
// optional sticky edge flags and a combined interrupt.
// Optional feature macro: PLC_IN_EDGE_EN (edge flags, flag_clr and irq).
module plc_input_filter
    import plc_pkg::*;
#(
    parameter int CHANNELS        = PLC_IN_CHANNELS,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] filt_out,
    output logic [CHANNELS-1:0] rise_flag,
    output logic [CHANNELS-1:0] fall_flag,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic                irq
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            plc_debounce_ch #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk_in    (clk_in),
                .rst_in    (rst_in),
                .raw_in    (raw_in[gi]),
                .flag_clr  (flag_clr[gi]),
                .filt_out  (filt_out[gi]),
                .rise_flag (rise_flag[gi]),
                .fall_flag (fall_flag[gi])
            );
        end
    endgenerate

`ifdef PLC_IN_EDGE_EN
    // Interrupt is an OR of registered flags only, so it cannot glitch.
    assign irq = |(rise_flag | fall_flag);
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_plc_input_filter.sv
// Directed bench for plc_input_filter (CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Flag/irq expectations follow PLC_IN_EDGE_EN.
module tb_plc_input_filter;

`ifdef PLC_IN_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk_in;
    logic       rst_in;
    logic [3:0] raw_in;
    logic [3:0] filt_out;
    logic [3:0] rise_flag;
    logic [3:0] fall_flag;
    logic [3:0] flag_clr;
    logic       irq;

    int total;
    int bad;

    plc_input_filter #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (raw_in),
        .filt_out  (filt_out),
        .rise_flag (rise_flag),
        .fall_flag (fall_flag),
        .flag_clr  (flag_clr),
        .irq       (irq)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance n rising edges; sample/drive 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [3:0] fx(input logic [3:0] v);
        return EDGE_EN ? v : 4'h0;
    endfunction

    task automatic chk_all(input string tag, input logic [3:0] f, input logic [3:0] r,
                           input logic [3:0] fl);
        chk({tag, ".filt"}, filt_out, f);
        chk({tag, ".rise"}, rise_flag, fx(r));
        chk({tag, ".fall"}, fall_flag, fx(fl));
        chk({tag, ".irq"}, {3'b000, irq}, {3'b000, |fx(r | fl)});
    endtask

    task automatic clear(input logic [3:0] m);
        flag_clr = m;
        tick(1);
        flag_clr = 4'h0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_in   = 1'b0;
        raw_in   = 4'hF;
        flag_clr = 4'h0;

        // 1. Reset state, then release with all inputs high
        tick(3);
        chk_all("rst", 4'h0, 4'h0, 4'h0);
        rst_in = 1'b1;
        tick(5);
        chk_all("rel5", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("rel6", 4'hF, 4'hF, 4'h0);
        clear(4'hF);
        chk_all("clrall", 4'hF, 4'h0, 4'h0);

        // 2. Channel 0: bring low, then rise again and clear
        raw_in = 4'hE;
        tick(6);
        chk_all("c0low", 4'hE, 4'h0, 4'h1);
        clear(4'h1);
        chk_all("c0clr", 4'hE, 4'h0, 4'h0);
        raw_in = 4'hF;
        tick(5);
        chk_all("c0r5", 4'hE, 4'h0, 4'h0);
        tick(1);
        chk_all("c0r6", 4'hF, 4'h1, 4'h0);
        clear(4'h1);
        chk_all("c0rclr", 4'hF, 4'h0, 4'h0);

        // 3. Channel 1: 3-cycle pulse rejected, 4-cycle pulse passes
        raw_in = 4'hD;
        tick(6);
        chk_all("c1low", 4'hD, 4'h0, 4'h2);
        clear(4'h2);
        raw_in = 4'hF;
        tick(3);
        raw_in = 4'hD;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("p3.filt", filt_out, 4'hD);
        end
        chk_all("p3", 4'hD, 4'h0, 4'h0);
        raw_in = 4'hF;
        tick(4);
        raw_in = 4'hD;
        tick(1);
        chk("p4.pre", filt_out, 4'hD);
        tick(1);
        chk_all("p4.up", 4'hF, 4'h2, 4'h0);
        tick(3);
        chk("p4.hold", filt_out, 4'hF);
        tick(1);
        chk_all("p4.down", 4'hD, 4'h2, 4'h2);
        clear(4'h2);
        chk_all("p4.clr", 4'hD, 4'h0, 4'h0);

        // 4. Channel 2: clear coinciding with a rise, set wins
        raw_in = 4'h9;
        tick(6);
        chk_all("c2low", 4'h9, 4'h0, 4'h4);
        clear(4'h4);
        raw_in = 4'hF;
        tick(5);
        flag_clr = 4'h4;
        tick(1);
        flag_clr = 4'h0;
        chk_all("setwin", 4'hF, 4'h4, 4'h0);
        tick(1);
        chk_all("setwin2", 4'hF, 4'h4, 4'h0);
        clear(4'h4);
        chk_all("c2clr", 4'hF, 4'h0, 4'h0);

        // 5. Channel 3: chatter every 2 cycles, then settle high
        raw_in = 4'h7;
        tick(6);
        chk_all("c3low", 4'h7, 4'h0, 4'h8);
        clear(4'h8);
        for (int k = 0; k < 10; k++) begin
            raw_in[3] = ~raw_in[3];
            tick(2);
            chk("chat.filt", filt_out, 4'h7);
        end
        chk_all("chat", 4'h7, 4'h0, 4'h0);
        raw_in[3] = 1'b1;
        tick(5);
        chk("set5", filt_out, 4'h7);
        tick(1);
        chk_all("set6", 4'hF, 4'h8, 4'h0);
        tick(4);
        chk_all("set10", 4'hF, 4'h8, 4'h0);

        // 6. Async reset in the middle of a count
        clear(4'hF);
        raw_in = 4'hE;
        tick(4);
        rst_in = 1'b0;
        #1;
        chk_all("arst", 4'h0, 4'h0, 4'h0);
        tick(2);
        raw_in = 4'hF;
        rst_in = 1'b1;
        tick(5);
        chk_all("arst5", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("arst6", 4'hF, 4'hF, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
